// File: rtl/shift_arb_seq_if.sv
// Handshake/bus bundle between two shift clients and the shared shift_arb_seq sequencer.
// master = client side, slave = sequencer side.
interface shift_arb_seq_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
);
    logic             req_0;
    logic [WIDTH-1:0] data_0;
    logic [AMT_W-1:0] amt_0;
    logic [1:0]       op_0;
    logic             req_1;
    logic [WIDTH-1:0] data_1;
    logic [AMT_W-1:0] amt_1;
    logic [1:0]       op_1;
    logic             gnt_0;
    logic             gnt_1;
    logic             busy;
    logic             done;
    logic             out_id;
    logic [WIDTH-1:0] result;

    modport master (
        output req_0, data_0, amt_0, op_0,
        output req_1, data_1, amt_1, op_1,
        input  gnt_0, gnt_1, busy, done, out_id, result
    );

    modport slave (
        input  req_0, data_0, amt_0, op_0,
        input  req_1, data_1, amt_1, op_1,
        output gnt_0, gnt_1, busy, done, out_id, result
    );
endinterface

// File: rtl/shift_arb_seq.sv
// Round-robin two-requester scheduler sharing one iterative (bit-per-cycle) shifter.
// Optional macro SHIFT_FAST2_EN: retire two shift steps per cycle while two or more remain.
//
// state | meaning
// IDLE  | waiting for a request; grants are combinational here only
// SHIFT | applying shift steps, count holds remaining steps
// DONE  | result valid, done pulse, returns to IDLE next edge
module shift_arb_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    shift_arb_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic [1:0]       op_q, op_d;
    logic             id_q, id_d;
    logic             last_gnt_q, last_gnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             out_id_q, out_id_d;
    logic             win_0, win_1;
    logic             sel;
    logic [AMT_W-1:0] amt_sel;

    function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] v, input logic [1:0] op);
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
            OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = {v[WIDTH-2:0], v[WIDTH-1]};
        endcase
        return r;
    endfunction

    // Tie goes to whichever requester was not granted last.
    always_comb begin
        win_0 = bus.req_0 && (!bus.req_1 || last_gnt_q);
        win_1 = bus.req_1 && (!bus.req_0 || !last_gnt_q);
    end

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        count_d    = count_q;
        op_d       = op_q;
        id_d       = id_q;
        last_gnt_d = last_gnt_q;
        result_d   = result_q;
        out_id_d   = out_id_q;
        sel        = win_1;
        amt_sel    = win_1 ? bus.amt_1 : bus.amt_0;

        case (state_q)
            S_IDLE: begin
                if (win_0 || win_1) begin
                    id_d       = sel;
                    last_gnt_d = sel;
                    work_d     = sel ? bus.data_1 : bus.data_0;
                    op_d       = sel ? bus.op_1 : bus.op_0;
                    count_d    = amt_sel;
                    state_d    = (amt_sel == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
`ifdef SHIFT_FAST2_EN
                if (count_q >= AMT_W'(2)) begin
                    work_d  = step1(step1(work_q, op_q), op_q);
                    count_d = count_q - AMT_W'(2);
                    if (count_q == AMT_W'(2)) state_d = S_DONE;
                end else begin
                    work_d  = step1(work_q, op_q);
                    count_d = count_q - AMT_W'(1);
                    state_d = S_DONE;
                end
`else
                work_d  = step1(work_q, op_q);
                count_d = count_q - AMT_W'(1);
                if (count_q == AMT_W'(1)) state_d = S_DONE;
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Result and owner are captured on DONE entry so they hold until the next done.
        if (state_d == S_DONE && state_q != S_DONE) begin
            result_d = work_d;
            out_id_d = id_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            work_q     <= '0;
            count_q    <= '0;
            op_q       <= '0;
            id_q       <= 1'b0;
            last_gnt_q <= 1'b1;
            result_q   <= '0;
            out_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            count_q    <= count_d;
            op_q       <= op_d;
            id_q       <= id_d;
            last_gnt_q <= last_gnt_d;
            result_q   <= result_d;
            out_id_q   <= out_id_d;
        end
    end

    assign bus.gnt_0  = (state_q == S_IDLE) && win_0;
    assign bus.gnt_1  = (state_q == S_IDLE) && win_1;
    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.out_id = out_id_q;
    assign bus.result = result_q;

endmodule

// File: doc/shift_arb_seq.md
Name: shift_arb_seq

Overview:
Two-requester scheduler that shares one iterative shift unit. It arbitrates round-robin between the requesters, captures an operand, amount and opcode, and sequences a shift of one bit position per cycle. It returns the result with a done pulse tagged by requester ID. It sits between client blocks and the shift datapath, replacing per-client shifters where area matters more than latency.

Parameters:
WIDTH, 8, operand/result width in bits
AMT_W, 3, shift-amount width; amounts 0..2^AMT_W-1 (must be <= WIDTH-1 range for WIDTH=8)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
req_0  input  1  requester 0 request; held until gnt_0
data_0  input  WIDTH  requester 0 operand
amt_0  input  AMT_W  requester 0 shift amount
op_0  input  2  requester 0 op: 00 SLL, 01 SRL, 10 SRA, 11 ROL
req_1, data_1, amt_1, op_1  input  1/WIDTH/AMT_W/2  same as above for requester 1
gnt_0  output  1  requester 0 accepted this cycle
gnt_1  output  1  requester 1 accepted this cycle
busy  output  1  sequencer not in IDLE
done  output  1  one-cycle result-valid pulse
out_id  output  1  requester that owns result
result  output  WIDTH  shifted value; held until next done

Behaviour:
- Reset (async, immediate): state IDLE, done=0, busy=0, out_id=0, result=0, count=0, last_gnt=1 (requester 0 wins first tie).
- States: IDLE, SHIFT, DONE.
- gnt_N is combinational: high only in IDLE when req_N is high and N wins arbitration. The clock edge with gnt high is the capture edge.
- Arbitration: single request wins outright. On a tie, grant goes to the requester not equal to last_gnt. last_gnt updates on every grant.
- Capture: working register <= data_N, count <= amt_N, op and id latched. If amt_N == 0, go to DONE, else go to SHIFT.
- SHIFT, each edge: apply one 1-bit step of the op, count <= count-1. When count == 1 at that edge, go to DONE.
- 1-bit steps:
  - SLL: shift left, fill 0.
  - SRL: shift right, fill 0.
  - SRA: shift right, fill MSB (sign replicate).
  - ROL: shift left, MSB wraps into LSB.
- DONE: done=1, result=working register, out_id=latched id. Next edge returns to IDLE. Requests are sampled again from IDLE only; there is no back-to-back grant in DONE.
- Latency: done is high in the cycle starting amt+1 edges after the capture edge. amt=0 gives 1 edge.
- busy=1 in SHIFT and DONE. Requests are ignored while busy; gnt stays 0.
- Changes to data/amt/op after capture have no effect.
- Reset mid-operation: the operation is aborted, no done is issued, and the requester must re-request.

Optional Feature:
SHIFT_FAST2_EN
- Defined: in SHIFT, when count >= 2, apply two 1-bit steps per edge and set count <= count-2. When count == 1, apply one step. Transition to DONE happens on the edge where count reaches 0. Shift-phase edges become ceil(amt/2). Results are identical to the undefined case.
- Undefined: exactly one bit per cycle, as above.

Test Plan:
- req_0, data_0=8'b1010_0000, amt_0=3, op=SRA -> gnt_0 high in capture cycle; done 4 edges later; result=8'b1111_0100; out_id=0.
- req_1, data_1=8'h5A, amt_1=0, op=SLL -> done 1 edge after capture; result=8'h5A; out_id=1.
- req_0=req_1=1 held continuously from reset, amt=1 -> grants alternate 0,1,0. Each done carries the matching out_id. busy gaps are exactly one IDLE cycle.
- op=ROL, data=8'h81, amt=1 -> 8'h03. op=SRL, data=8'h81, amt=7 -> 8'h01. op=SLL, data=8'h81, amt=7 -> 8'h80.
- rst pulsed mid-SHIFT (amt=6, after 2 edges) -> all outputs 0 immediately; no done. A new req_1 afterward is granted and completes normally.
- With SHIFT_FAST2_EN: amt=5, SRA, data=8'h80 -> done 4 edges after capture (vs 6); result=8'hFC.
